// File: rtl/spdif_sample_buffer.sv
// Frame-assembling sample FIFO between the S/PDIF decoder (60 MHz) and the frame
// assembler; frames leave over a toggle req/ack handshake with prefill muting.
module spdif_sample_buffer #(
  parameter int SAMPLE_W    = 20,
  parameter int OUT_W       = 16,
  parameter int CHANNELS    = 2,
  parameter int DEPTH       = 64,
  parameter int START_LEVEL = DEPTH / 2,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                      clk_60mhz,
  input  logic                      rst,
  input  logic                      vin,
  input  logic [SAMPLE_W-1:0]       din,
  input  logic [CH_W-1:0]           ch_in,
  input  logic                      req_toggle,
  output logic                      ack_toggle,
  output logic [CHANNELS*OUT_W-1:0] dout,
  output logic                      muted,
  output logic [AW:0]               level,
  output logic [7:0]                underrun_cnt,
  output logic [7:0]                overflow_cnt,
  output logic [7:0]                seq_err_cnt
);

  localparam int FRAME_W = CHANNELS * OUT_W;
  localparam logic [1:0] SVC_IDLE  = 2'd0;
  localparam logic [1:0] SVC_DATA  = 2'd1;
  localparam logic [1:0] SVC_MUTE  = 2'd2;
  localparam logic [1:0] SVC_UNDER = 2'd3;
  localparam logic [CH_W-1:0] LAST_CH     = CH_W'(CHANNELS - 1);
  localparam logic [CH_W-1:0] CH_ONE      = CH_W'(1);
  localparam logic [AW:0]     PTR_ONE     = (AW + 1)'(1);
  localparam logic [AW:0]     LEVEL_START = (AW + 1)'(START_LEVEL);

  logic [OUT_W-1:0]   lane_q [CHANNELS];
  logic [OUT_W-1:0]   lane_d [CHANNELS];
  logic [CH_W-1:0]    expected_q, expected_d;
  logic               frame_valid_q, frame_valid_d;
  logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
  logic               sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
  logic [1:0]         svc_q, svc_d;
  logic [FRAME_W-1:0] dout_q, dout_d, frame_data, rd_data_q;
  logic               muted_q, muted_d, ack_q, ack_d;
  logic [7:0]         und_q, und_d, ovf_q, ovf_d, seq_q, seq_d;
  logic [FRAME_W-1:0] mem [DEPTH];
  logic               full, empty, wr_en, rd_en, pop_evt;
  logic               din_unused;

  // Only the top OUT_W bits of each sample are kept.
  assign din_unused = ^din;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A mismatched channel index abandons the partial frame; a stray channel 0
  // is taken as the start of a fresh frame rather than thrown away.
  always_comb begin
    lane_d        = lane_q;
    expected_d    = expected_q;
    frame_valid_d = 1'b0;
    seq_d         = seq_q;
    if (vin) begin
      if (ch_in == expected_q) begin
        lane_d[expected_q] = din[SAMPLE_W-1 -: OUT_W];
        if (expected_q == LAST_CH) begin
          expected_d    = '0;
          frame_valid_d = 1'b1;
        end else begin
          expected_d = expected_q + CH_ONE;
        end
      end else begin
        seq_d = sat_inc(seq_q);
        if (ch_in == '0) begin
          lane_d[0]  = din[SAMPLE_W-1 -: OUT_W];
          expected_d = CH_ONE;
        end else begin
          expected_d = '0;
        end
      end
    end
  end

  always_comb begin
    frame_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      frame_data[i*OUT_W +: OUT_W] = lane_q[i];
    end
  end

  // Fullness is judged on the registered pointers, so a pop landing in the
  // same cycle cannot make room for an incoming frame.
  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    wr_en    = frame_valid_q && !full;
    pop_evt  = (sync2_q != hist_q);
    rd_en    = pop_evt && !muted_q && !empty;
    ovf_d    = (frame_valid_q && full) ? sat_inc(ovf_q) : ovf_q;
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d  = wr_ptr_d - rd_ptr_d;
    sync1_d  = req_toggle;
    sync2_d  = sync1_q;
    hist_d   = sync2_q;
  end

  // The pop decision is taken alongside the RAM read; outputs follow one
  // cycle later so dout and ack_toggle always move on the same edge.
  always_comb begin
    svc_d = SVC_IDLE;
    if (pop_evt) begin
      if (muted_q)    svc_d = SVC_MUTE;
      else if (empty) svc_d = SVC_UNDER;
      else            svc_d = SVC_DATA;
    end
    dout_d  = dout_q;
    ack_d   = ack_q;
    und_d   = und_q;
    muted_d = muted_q;
    if (level_q >= LEVEL_START) muted_d = 1'b0;
    case (svc_q)
      SVC_DATA: begin
        dout_d = rd_data_q;
        ack_d  = ~ack_q;
      end
      SVC_MUTE: begin
        dout_d = '0;
        ack_d  = ~ack_q;
      end
      SVC_UNDER: begin
        dout_d  = '0;
        ack_d   = ~ack_q;
        muted_d = 1'b1;
        und_d   = sat_inc(und_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_60mhz) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) lane_q[i] <= '0;
      expected_q    <= '0;
      frame_valid_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      hist_q        <= 1'b0;
      svc_q         <= SVC_IDLE;
      dout_q        <= '0;
      muted_q       <= 1'b1;
      ack_q         <= 1'b0;
      und_q         <= '0;
      ovf_q         <= '0;
      seq_q         <= '0;
    end else begin
      lane_q        <= lane_d;
      expected_q    <= expected_d;
      frame_valid_q <= frame_valid_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      hist_q        <= hist_d;
      svc_q         <= svc_d;
      dout_q        <= dout_d;
      muted_q       <= muted_d;
      ack_q         <= ack_d;
      und_q         <= und_d;
      ovf_q         <= ovf_d;
      seq_q         <= seq_d;
    end
  end

  always_ff @(posedge clk_60mhz) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= frame_data;
    if (rd_en) rd_data_q <= mem[rd_ptr_q[AW-1:0]];
  end

  assign dout         = dout_q;
  assign ack_toggle   = ack_q;
  assign muted        = muted_q;
  assign level        = level_q;
  assign underrun_cnt = und_q;
  assign overflow_cnt = ovf_q;
  assign seq_err_cnt  = seq_q;

endmodule

// File: tb/tb_spdif_sample_buffer.sv
// Directed bench for spdif_sample_buffer at default parameters: 2 channels,
// 20->16 bit lanes, 64-frame FIFO, unmute at 32 frames.
`timescale 1ns/1ps
module tb_spdif_sample_buffer;

  localparam int DEPTH = 64;

  typedef struct {
    logic [19:0] left;
    logic [19:0] right;
    logic [31:0] exp_dout;
  } vec_t;

  logic        clk_60mhz = 1'b0;
  logic        rst = 1'b1;
  logic        vin = 1'b0;
  logic [19:0] din = '0;
  logic [0:0]  ch_in = '0;
  logic        req_toggle = 1'b0;
  logic        ack_toggle;
  logic [31:0] dout;
  logic        muted;
  logic [6:0]  level;
  logic [7:0]  underrun_cnt, overflow_cnt, seq_err_cnt;

  int          errors = 0;
  int          checks = 0;
  vec_t        vecs[4];
  logic [31:0] exp_frames[$];
  int          model_level = 0;
  int          model_ovf = 0;

  spdif_sample_buffer dut (
    .clk_60mhz   (clk_60mhz),
    .rst         (rst),
    .vin         (vin),
    .din         (din),
    .ch_in       (ch_in),
    .req_toggle  (req_toggle),
    .ack_toggle  (ack_toggle),
    .dout        (dout),
    .muted       (muted),
    .level       (level),
    .underrun_cnt(underrun_cnt),
    .overflow_cnt(overflow_cnt),
    .seq_err_cnt (seq_err_cnt)
  );

  always #8 clk_60mhz = ~clk_60mhz;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [0:0] ch, input logic [19:0] data);
    @(negedge clk_60mhz);
    vin   = 1'b1;
    ch_in = ch;
    din   = data;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_60mhz);
      vin = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [19:0] l, input logic [19:0] r);
    applyStimulus(1'b0, l);
    applyStimulus(1'b1, r);
    if (model_level < DEPTH) begin
      exp_frames.push_back({r[19:4], l[19:4]});
      model_level++;
    end else begin
      model_ovf++;
    end
  endtask

  // Toggles req and requires ack to move within 4 clocks.
  task automatic do_request(input string name);
    logic prev;
    int   cyc;
    @(negedge clk_60mhz);
    prev       = ack_toggle;
    req_toggle = ~req_toggle;
    cyc        = 0;
    do begin
      @(negedge clk_60mhz);
      cyc++;
    end while (ack_toggle == prev && cyc < 12);
    checks++;
    if (ack_toggle == prev || cyc > 4) begin
      errors++;
      $display("[TB] FAIL %s ack latency: got %0d cycles, required <= 4", name, cyc);
    end
  endtask

  task automatic pop_and_check(input string name);
    logic [31:0] exp;
    do_request(name);
    exp = (exp_frames.size() > 0) ? exp_frames.pop_front() : 32'hDEAD_BEEF;
    model_level--;
    checkOutput(name, dout, exp);
  endtask

  function automatic logic [19:0] left_of(input int i);
    return (i < 4) ? vecs[i].left : {16'(i) ^ 16'h5A00, 4'hC};
  endfunction

  function automatic logic [19:0] right_of(input int i);
    return (i < 4) ? vecs[i].right : {16'hF000 | 16'(i), 4'h3};
  endfunction

  initial begin
    vecs[0] = '{20'hABCDE, 20'h13579, 32'h1357_ABCD};
    vecs[1] = '{20'h12345, 20'h6789A, 32'h6789_1234};
    vecs[2] = '{20'hFFFFF, 20'h0000F, 32'h0000_FFFF};
    vecs[3] = '{20'h8000F, 20'h7FFF0, 32'h7FFF_8000};

    repeat (3) @(negedge clk_60mhz);
    checkOutput("reset level", 32'(level), 32'd0);
    checkOutput("reset muted", 32'(muted), 32'd1);
    checkOutput("reset ack", 32'(ack_toggle), 32'd0);
    checkOutput("reset dout", dout, 32'd0);
    checkOutput("reset counters", {8'd0, underrun_cnt, overflow_cnt, seq_err_cnt}, 32'd0);
    rst = 1'b0;

    // Prefill: 31 frames keep the output muted.
    for (int i = 0; i < 31; i++) send_frame(left_of(i), right_of(i));
    idle(4);
    checkOutput("prefill level 31", 32'(level), 32'd31);
    for (int i = 0; i < 3; i++) begin
      do_request("muted req");
      checkOutput("muted dout", dout, 32'd0);
      checkOutput("muted flag", 32'(muted), 32'd1);
    end
    checkOutput("muted level untouched", 32'(level), 32'd31);

    send_frame(left_of(31), right_of(31));
    idle(4);
    checkOutput("level 32", 32'(level), 32'd32);
    checkOutput("mute exit", 32'(muted), 32'd0);

    // Drain all 32 frames; the first four come from the hand-computed table.
    for (int i = 0; i < 32; i++) begin
      logic [31:0] exp;
      do_request("drain req");
      exp = exp_frames.pop_front();
      model_level--;
      if (i < 4) checkOutput("table frame", dout, vecs[i].exp_dout);
      else       checkOutput("drain frame", dout, exp);
      if (i == 0) checkOutput("level after first pop", 32'(level), 32'd31);
    end
    checkOutput("drained level", 32'(level), 32'd0);

    do_request("underrun req");
    checkOutput("underrun dout", dout, 32'd0);
    checkOutput("underrun muted", 32'(muted), 32'd1);
    checkOutput("underrun count", 32'(underrun_cnt), 32'd1);

    // Channel sequence 0,0,1: frame built from the second ch0 sample.
    applyStimulus(1'b0, 20'h11111);
    applyStimulus(1'b0, 20'h22222);
    applyStimulus(1'b1, 20'h33333);
    idle(4);
    checkOutput("seq err count", 32'(seq_err_cnt), 32'd1);
    checkOutput("seq err level", 32'(level), 32'd1);
    exp_frames.push_back(32'h3333_2222);
    model_level = 1;

    // Fill to 64 and push 3 frames past full.
    for (int i = 100; i < 166; i++) send_frame(left_of(i), right_of(i));
    idle(4);
    checkOutput("full level", 32'(level), 32'd64);
    checkOutput("overflow count", 32'(overflow_cnt), 32'(model_ovf));
    checkOutput("overflow count is 3", 32'(overflow_cnt), 32'd3);
    checkOutput("full unmuted", 32'(muted), 32'd0);
    for (int i = 0; i < 64; i++) pop_and_check("overflow order");
    checkOutput("empty after overflow drain", 32'(level), 32'd0);

    // Reset with 10 frames stored, a partial frame and a request in flight.
    for (int i = 200; i < 210; i++) send_frame(left_of(i), right_of(i));
    idle(4);
    checkOutput("pre-reset level", 32'(level), 32'd10);
    applyStimulus(1'b0, 20'h44444);
    @(negedge clk_60mhz);
    vin        = 1'b0;
    req_toggle = ~req_toggle;
    @(negedge clk_60mhz);
    rst = 1'b1;
    @(negedge clk_60mhz);
    checkOutput("mid reset level", 32'(level), 32'd0);
    checkOutput("mid reset counters", {8'd0, underrun_cnt, overflow_cnt, seq_err_cnt}, 32'd0);
    checkOutput("mid reset muted", 32'(muted), 32'd1);
    checkOutput("mid reset ack", 32'(ack_toggle), 32'd0);
    rst = 1'b0;
    exp_frames.delete();
    model_level = 0;
    model_ovf   = 0;

    // req_toggle is still high, so exactly one muted pop follows reset.
    repeat (8) @(negedge clk_60mhz);
    checkOutput("post reset pop ack", 32'(ack_toggle), 32'd1);
    checkOutput("post reset pop dout", dout, 32'd0);
    checkOutput("post reset underrun", 32'(underrun_cnt), 32'd0);

    for (int i = 0; i < 364; i++) send_frame(left_of(i + 300), right_of(i + 300));
    idle(4);
    checkOutput("saturate level", 32'(level), 32'd64);
    checkOutput("overflow saturates", 32'(overflow_cnt), 32'd255);
    checkOutput("partial frame cleared", 32'(seq_err_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
